key_debounce_4: RTL
===================

Name: key_debounce_4

Overview:
- Four-channel pushbutton front end.
- Synchronises raw board keys to clk and debounces each channel independently with a per-channel stability counter.
- Outputs are:
  - clean key levels, which drive the 4-to-2 encoder's A[3:0] input directly;
  - single-cycle press pulses;
  - a held one-hot "last key pressed" register, which gives the encoder a stable one-hot input after the key is released.

Parameters:
- STABLE_CYCLES, 1000000, consecutive clk cycles a synchronised key must differ from its debounced level before the level flips. This is 10 ms at 100 MHz. Legal range is >= 2.
- CNT_W, $clog2(STABLE_CYCLES), width of each per-channel counter. It is derived and must not be overridden.

Ports:
- clk  input  1  system clock; all flops update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  4  raw asynchronous key levels; 1 = pressed.
- key_level  output  4  debounced key levels; feeds the encoder's A.
- key_press  output  4  one-cycle pulse per channel on a debounced 0->1 transition.
- key_latch  output  4  one-hot copy of the most recent press; 0000 until the first press.
- latch_valid  output  1  1 once key_latch holds a press; cleared only by rst.

Behaviour:
- Reset: when rst=1 at a clk edge, all of the following clear to 0:
  - synchroniser flops;
  - counters;
  - key_level, key_press, key_latch, latch_valid.
  - rst overrides every other action in that cycle, including mid-count.
- Synchroniser: two flops per channel, key_in -> s1 -> s2. Only s2 is used downstream.
- Per channel i, at each edge:
  - if s2[i] == key_level[i]: cnt[i] <= 0.
  - else if cnt[i] == STABLE_CYCLES-1: key_level[i] <= s2[i] and cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- Latency:
  - A clean key_in change captured at edge E changes key_level at edge E+STABLE_CYCLES+1.
  - key_level is therefore visible STABLE_CYCLES+2 cycles after key_in settles.
  - Release has the same latency.
- Glitch rejection:
  - Any return of s2[i] to key_level[i] before the count completes zeroes cnt[i]. The count restarts from 0 on the next difference.
  - Pulses of s2 shorter than STABLE_CYCLES cycles never reach key_level.
- key_press[i]:
  - Registered in the same edge that sets key_level[i] 0->1, so it rises in the same cycle as key_level.
  - High for exactly one cycle.
  - Never asserted on release.
- key_latch update, evaluated from the key_press pulse in the cycle it is high; effect appears at the following edge:
  - If key_press == 0000: hold.
  - Otherwise key_latch <= the highest-index set bit of key_press, as a one-hot value, and latch_valid <= 1.
  - Simultaneous presses resolve by priority. For example key_press 0101 gives key_latch 0100.
- key_latch never shows more than one bit and is not cleared by release.
- key_level is not priority-filtered. Multiple held keys appear as-is, and the downstream encoder handles them.
- Channels are fully independent. There is no state machine beyond the per-channel counter, which acts as a two-state IDLE/COUNTING machine.

Test Plan (STABLE_CYCLES=4, so level latency is 6 cycles):
1. Reset mid-count: key_in=0001, 3 cycles later rst=1 for 1 cycle.
   - All outputs are 0 in the cycle after rst.
   - key_level[0] rises only after a fresh 6-cycle window.
2. Clean press: key_in 0000->0010 and held.
   - key_level=0010 and key_press=0010 for one cycle, 6 cycles later.
   - key_latch=0010 and latch_valid=1 one cycle after that.
3. Bounce: key_in[2] toggles 1,0,1,0 at 2-cycle spacing, then holds 1.
   - No key_press during the bounce.
   - Single key_press=0100 six cycles after the final settle.
4. Glitch: key_in=1000 for 3 cycles, then 0000.
   - key_level, key_press and key_latch stay 0000 throughout.
5. Simultaneous press: key_in 0000->0101 in one cycle.
   - key_level=0101 and key_press=0101 together.
   - Next cycle key_latch=0100.
6. Release: after scenario 2, key_in->0000.
   - key_level=0000 after 6 cycles.
   - No key_press.
   - key_latch stays 0010 and latch_valid stays 1.

Source files
------------

// File: rtl/key_debounce_4.sv
// -----------------------------------------------------------------------------
// key_debounce_4
//
// Four-channel pushbutton front end. Each raw key is brought into the clk
// domain through a two-flop synchroniser. It is then debounced by its own
// stability counter. The module also produces a one-cycle press pulse per
// channel and a held one-hot record of the most recent press.
//
// Parameters
//   STABLE_CYCLES : consecutive cycles the synchronised key must disagree with
//                   the debounced level before the level flips (>= 2).
//   CNT_W         : counter width, derived from STABLE_CYCLES; do not override.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   key_in      in   [3:0] raw asynchronous key levels, 1 = pressed
//   key_level   out  [3:0] debounced key levels (feeds the encoder's A input)
//   key_press   out  [3:0] one-cycle pulse on each debounced 0->1 transition
//   key_latch   out  [3:0] one-hot copy of the most recent press, 0 until first
//   latch_valid out  1 once key_latch holds a press; cleared only by rst
//
// Timing: a key_in change captured at edge E shows on key_level at edge
// E+STABLE_CYCLES+1. key_press rises at that same edge. key_latch/latch_valid
// follow one edge later.
// -----------------------------------------------------------------------------
module key_debounce_4 #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_latch,
    output logic       latch_valid
);

    localparam int               NUM_KEYS = 4;
    // Terminal count: the level flips on the edge where the counter already
    // holds STABLE_CYCLES-1. That edge is the STABLE_CYCLES-th consecutive
    // edge seeing a difference.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Per-channel synchroniser + debouncer
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            logic             sync1_q;
            logic             sync2_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             level_q;
            logic             level_d;
            logic             press_q;
            logic             press_d;

            // The counter behaves as a two-state machine. It is IDLE while
            // cnt_q == 0 and the input agrees with the level. It is COUNTING
            // while the input disagrees. Any agreement returns it to IDLE, so
            // a bounce always restarts the full window.
            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                press_d = 1'b0;
                if (sync2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                    // Pulse only on the rising debounced transition.
                    press_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= key_in[gi];
                    sync2_q <= sync1_q;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    press_q <= press_d;
                end
            end

            assign key_level[gi] = level_q;
            assign key_press[gi] = press_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Last-key-pressed register
    // -------------------------------------------------------------------------
    // Evaluated from the registered press pulses. The result therefore appears
    // one edge after key_press. When several channels press in the same cycle,
    // the highest index wins, so key_latch stays strictly one-hot for the
    // encoder.
    logic [3:0] latch_q;
    logic [3:0] latch_d;
    logic       valid_q;
    logic       valid_d;

    always_comb begin
        latch_d = latch_q;
        valid_d = valid_q;
        if (key_press != 4'b0000) begin
            valid_d = 1'b1;
            casez (key_press)
                4'b1???: latch_d = 4'b1000;
                4'b01??: latch_d = 4'b0100;
                4'b001?: latch_d = 4'b0010;
                default: latch_d = 4'b0001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            valid_q <= valid_d;
        end
    end

    assign key_latch   = latch_q;
    assign latch_valid = valid_q;

endmodule
